forest_vote_engine: RTL and testbench
=====================================

Name: forest_vote_engine

Overview:
- Parametrised result stage for the tree-engine array. Collects each tree's leaf value once every engine reports done.
- Two modes. Class mode: majority vote over N_CLASSES with tie-break to the lowest index. Sum mode: saturated signed sum.
- Votes and classes are processed serially, one per cycle, to bound area.
- Detects stale done flags left from the previous run, and flags a timeout if the trees never finish.

Parameters:
N_TREES, 16, number of tree engines (>=1)
N_CLASSES, 32, number of vote classes (>=2)
TIMEOUT_CYC, 4096, maximum cycles in WAIT before the error abort (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; accepted only when busy=0
mode  in  1  0=class vote, 1=saturated sum; sampled when start is accepted
tree_done  in  N_TREES  per-engine done level
leaf_vals  in  32*N_TREES  tree t uses bits [32t+31:32t]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the result is valid
error  out  1  timeout flag; valid with done, held until the next accepted start
result  out  32  signed result (class index zero-extended, or saturated sum); held
votes  out  $clog2(N_TREES+1)  vote count of the winning class (0 in sum mode); held
invalid_votes  out  $clog2(N_TREES+1)  class-mode leaves >= N_CLASSES; held

Behaviour:
- Reset: state IDLE. All outputs, class counters, accumulator, armed mask and timeout counter are cleared to 0. Reset asserted mid-operation aborts the run with no done pulse.
- Derived widths: CLS_W=$clog2(N_CLASSES), CNT_W=$clog2(N_TREES+1), ACC_W=32+$clog2(N_TREES)+1.
- IDLE:
  - On start, latch mode; clear counters, accumulator, armed mask, timeout counter, error and invalid_votes; go to WAIT.
  - start is ignored whenever busy=1.
- WAIT:
  - Set armed[t] in any cycle where tree_done[t]=0. This rejects done levels held over from the previous run.
  - all_done = &armed and &tree_done, evaluated on the armed mask updated in that cycle.
  - If all_done, go to ACCUM with t=0.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC, go to FIN with error=1, result=0, votes=0.
- ACCUM: one tree per cycle, t=0..N_TREES-1, leaf_vals sampled live.
  - Class mode: if the leaf is < N_CLASSES (unsigned compare on the full 32 bits), count[leaf]++; else invalid_votes++.
  - Sum mode: acc += sign-extend(leaf) to ACC_W.
  - After t=N_TREES-1: class mode goes to SELECT with c=0; sum mode goes to FIN.
- SELECT: one class per cycle, c=0..N_CLASSES-1.
  - Replace best only when count[c] > best_count (strict), so ties resolve to the lowest index.
  - If all counts are 0, result=0 and votes=0.
  - After c=N_CLASSES-1, go to FIN.
- FIN (one cycle):
  - Register result, votes and error.
  - Sum mode: result = acc clamped to [-2^31, 2^31-1].
  - Pulse done the next cycle, return to IDLE; busy drops with done.
- Latency from the first WAIT cycle in which all_done is true to done high:
  - class mode: N_TREES+N_CLASSES+2 cycles;
  - sum mode: N_TREES+2 cycles.
- Boundaries:
  - start in the same cycle as done is accepted.
  - tree_done falling during ACCUM is ignored.
  - N_TREES=1 is legal.
  - Counters cannot overflow by construction (CNT_W sizing).

Test Plan:
- Reset then idle: all outputs 0; start with tree_done held at all-ones from reset -> no exit from WAIT until each bit has toggled 0->1.
- Class mode, N_TREES=16: leaves 3,3,3,7,7,… (ten 3s, six 7s); tree_done falls and rises after start -> result=3, votes=10, invalid_votes=0, done exactly N_TREES+N_CLASSES+2 cycles after all_done.
- Tie plus invalid votes: eight leaves=5, six=2, two=40 (N_CLASSES=32), then a variant with eight 5s and eight 2s -> first case: result=5, votes=8, invalid_votes=2; variant: result=2.
- Sum mode: leaves alternating +100/-30 -> result=560; all leaves 0x7FFFFFFF -> result=0x7FFFFFFF; all 0x80000000 -> result=0x80000000.
- Timeout with TIMEOUT_CYC=64: one tree_done bit stuck low -> done 64+1 cycles after WAIT entry with error=1, result=0; the next start clears error.
- Robustness: start pulses while busy -> ignored, result unchanged; rst_n asserted during ACCUM -> outputs 0, no done pulse, IDLE.

Source files
------------

// File: rtl/forest_vote_engine.sv
// Result stage for the tree-engine array: waits for every engine to finish, then
// takes a serial majority vote over classes or a saturated signed sum of leaves.
module forest_vote_engine #(
  parameter int N_TREES     = 16,
  parameter int N_CLASSES   = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [N_TREES-1:0]              tree_done,
  input  logic [32*N_TREES-1:0]           leaf_vals,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [31:0]                     result,
  output logic [$clog2(N_TREES+1)-1:0]    votes,
  output logic [$clog2(N_TREES+1)-1:0]    invalid_votes
);

  localparam int CLS_W = $clog2(N_CLASSES);
  localparam int CNT_W = $clog2(N_TREES+1);
  localparam int ACC_W = 32 + $clog2(N_TREES) + 1;
  localparam int TI_W  = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC+1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCUM, S_SELECT, S_FIN} state_t;

  state_t                   state;
  logic                     mode_q;
  logic                     timed_out;
  logic [N_TREES-1:0]       armed;
  logic [TO_W-1:0]          to_cnt;
  logic [TI_W-1:0]          t_idx;
  logic [CLS_W-1:0]         c_idx;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count [N_CLASSES];
  logic [CNT_W-1:0]         best_cnt;
  logic [CLS_W-1:0]         best_idx;

  logic [N_TREES-1:0]       armed_nxt;
  logic                     all_done;
  logic [31:0]              leaf;
  logic                     leaf_valid;

  // A tree only counts as finished once its done line has been seen low in this run.
  assign armed_nxt  = armed | ~tree_done;
  assign all_done   = (&armed_nxt) & (&tree_done);
  assign leaf       = leaf_vals[32*t_idx +: 32];
  assign leaf_valid = leaf < 32'(N_CLASSES);

  // NOTE: all state lives in one clocked block with non-blocking assignments so every
  // read sees the value from the previous edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      timed_out     <= 1'b0;
      armed         <= '0;
      to_cnt        <= '0;
      t_idx         <= '0;
      c_idx         <= '0;
      acc           <= '0;
      best_cnt      <= '0;
      best_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      result        <= '0;
      votes         <= '0;
      invalid_votes <= '0;
      // NOTE: the class histogram is small and must read zero after reset, so it is
      // built from flops with a reset rather than inferred as a RAM.
      for (int c = 0; c < N_CLASSES; c++) count[c] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q        <= mode;
            timed_out     <= 1'b0;
            armed         <= '0;
            to_cnt        <= '0;
            acc           <= '0;
            error         <= 1'b0;
            invalid_votes <= '0;
            busy          <= 1'b1;
            for (int c = 0; c < N_CLASSES; c++) count[c] <= '0;
            state         <= S_WAIT;
          end
        end

        S_WAIT: begin
          armed <= armed_nxt;
          if (all_done) begin
            t_idx <= '0;
            state <= S_ACCUM;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC-1)) begin
            timed_out <= 1'b1;
            state     <= S_FIN;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_ACCUM: begin
          if (mode_q)
            acc <= acc + {{(ACC_W-32){leaf[31]}}, leaf};
          else if (leaf_valid)
            count[leaf[CLS_W-1:0]] <= count[leaf[CLS_W-1:0]] + CNT_W'(1);
          else
            invalid_votes <= invalid_votes + CNT_W'(1);

          if (t_idx == TI_W'(N_TREES-1)) begin
            c_idx    <= '0;
            best_cnt <= '0;
            best_idx <= '0;
            state    <= mode_q ? S_FIN : S_SELECT;
          end else begin
            t_idx <= t_idx + TI_W'(1);
          end
        end

        S_SELECT: begin
          // Strict compare keeps the earliest (lowest-index) class on a tie.
          if (count[c_idx] > best_cnt) begin
            best_cnt <= count[c_idx];
            best_idx <= c_idx;
          end
          if (c_idx == CLS_W'(N_CLASSES-1))
            state <= S_FIN;
          else
            c_idx <= c_idx + CLS_W'(1);
        end

        S_FIN: begin
          error <= timed_out;
          if (timed_out) begin
            result <= '0;
            votes  <= '0;
          end else if (mode_q) begin
            votes <= '0;
            if (acc > SAT_MAX)      result <= 32'h7FFF_FFFF;
            else if (acc < SAT_MIN) result <= 32'h8000_0000;
            else                    result <= acc[31:0];
          end else begin
            result <= 32'(best_idx);
            votes  <= best_cnt;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_forest_vote_engine.sv
// Randomised self-checking bench for forest_vote_engine against a histogram/sum model,
// plus directed cases for stale done levels, ties, saturation, timeout and reset.
module tb_forest_vote_engine;

  localparam int N_TREES     = 16;
  localparam int N_CLASSES   = 32;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = $clog2(N_TREES+1);
  localparam int LAT_CLASS   = N_TREES + N_CLASSES + 2;
  localparam int LAT_SUM     = N_TREES + 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   mode = 1'b0;
  logic [N_TREES-1:0]     tree_done = '1;
  logic [32*N_TREES-1:0]  leaf_vals = '0;
  logic                   busy, done, error;
  logic [31:0]            result;
  logic [CNT_W-1:0]       votes, invalid_votes;

  forest_vote_engine #(
    .N_TREES(N_TREES), .N_CLASSES(N_CLASSES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .tree_done(tree_done), .leaf_vals(leaf_vals),
    .busy(busy), .done(done), .error(error), .result(result),
    .votes(votes), .invalid_votes(invalid_votes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    int          votes;
    int          invalid;
    bit          error;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  bit          chk_en = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] leaves [N_TREES];
  exp_t        exp_job = '{32'd0, 0, 0, 1'b0};
  exp_t        held    = '{32'd0, 0, 0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: histogram + "highest count, lowest class holding it", or a wide sum then clamp.
  function automatic exp_t model(input bit m);
    exp_t   e;
    int     hist [N_CLASSES];
    longint s;
    int     top;
    e = '{32'd0, 0, 0, 1'b0};
    if (m) begin
      s = 0;
      foreach (leaves[i]) s += $signed(leaves[i]);
      if (s > 64'sd2147483647)       e.result = 32'h7FFF_FFFF;
      else if (s < -64'sd2147483648) e.result = 32'h8000_0000;
      else                           e.result = s[31:0];
    end else begin
      foreach (hist[c]) hist[c] = 0;
      foreach (leaves[i]) begin
        if (leaves[i] < 32'(N_CLASSES)) hist[leaves[i]]++;
        else                            e.invalid++;
      end
      top = 0;
      foreach (hist[c]) if (hist[c] > top) top = hist[c];
      if (top > 0) begin
        for (int c = N_CLASSES-1; c >= 0; c--) if (hist[c] == top) e.result = 32'(c);
        e.votes = top;
      end
    end
    return e;
  endfunction

  task automatic pack_leaves();
    for (int i = 0; i < N_TREES; i++) leaf_vals[32*i +: 32] = leaves[i];
  endtask

  // Compare process: result at every done pulse, held outputs on every idle cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '{32'd0, 0, 0, 1'b0};
    end else if (chk_en) begin
      if (done) begin
        done_cnt++;
        check("done_single_pulse", prev_done, 0);
        check("busy_low_with_done", busy, 0);
        check("result", result, exp_job.result);
        check("votes", votes, exp_job.votes);
        check("invalid_votes", invalid_votes, exp_job.invalid);
        check("error", error, exp_job.error);
        held = exp_job;
      end else if (!busy) begin
        check("held_result", result, held.result);
        check("held_votes", votes, held.votes);
        check("held_invalid", invalid_votes, held.invalid);
        check("held_error", error, held.error);
      end
    end
    prev_done = done;
  end

  // Starts a job (same cycle as a pending done pulse if called right after one), drives
  // tree_done until the model sees all_done, then measures latency to done.
  task automatic run_job(input bit m, input int stale_hold, input bit noisy);
    logic [N_TREES-1:0] seen;
    logic [N_TREES-1:0] td;
    int dc0, k;
    #1;
    exp_job = model(m);
    pack_leaves();
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'($urandom);
    check("busy_after_start", busy, 1);
    check("error_cleared_on_start", error, 0);
    dc0  = done_cnt;
    seen = '0;
    for (int j = 0; ; j++) begin
      if (stale_hold > 0 && j == stale_hold)
        check("stale_no_exit", {busy, done, done_cnt == dc0}, 3'b101);
      if (j < stale_hold)                 td = '1;
      else if (noisy && j < stale_hold + 30)
        td = ($urandom_range(0, 2) == 0) ? '1 : N_TREES'($urandom | $urandom);
      else                                td = (&seen) ? '1 : '0;
      tree_done = td;
      seen |= ~td;
      if ((&seen) && (&td)) break;
      if (noisy) begin
        start = ($urandom_range(0, 3) == 0);
        mode  = 1'($urandom);
      end
      @(negedge clk);
    end
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (done || k >= 200) break;
      if (noisy) begin
        start     = ($urandom_range(0, 3) == 0);
        mode      = 1'($urandom);
        tree_done = N_TREES'($urandom);
      end
    end
    start = 1'b0;
    check("latency", k, m ? LAT_SUM : LAT_CLASS);
  endtask

  task automatic fill(input logic [31:0] a, input int na, input logic [31:0] b,
                      input int nb, input logic [31:0] c);
    for (int i = 0; i < N_TREES; i++)
      leaves[i] = (i < na) ? a : (i < na + nb) ? b : c;
  endtask

  initial begin
    int k, dc0;
    foreach (leaves[i]) leaves[i] = '0;
    pack_leaves();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_result", result, 0);
    check("rst_votes", votes, 0);
    check("rst_invalid", invalid_votes, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Stale all-ones done levels, ten 3s and six 7s.
    fill(32'd3, 10, 32'd7, 6, 32'd7);
    run_job(1'b0, 8, 1'b0);
    check("maj_result", result, 3);
    check("maj_votes", votes, 10);
    check("maj_invalid", invalid_votes, 0);

    // Back-to-back start in the done cycle; busy start pulses with a flipping mode.
    fill(32'd5, 8, 32'd2, 6, 32'd40);
    run_job(1'b0, 0, 1'b1);
    check("tie_inv_result", result, 5);
    check("tie_inv_votes", votes, 8);
    check("tie_inv_invalid", invalid_votes, 2);

    fill(32'd5, 8, 32'd2, 8, 32'd2);
    run_job(1'b0, 0, 1'b0);
    check("tie_low_result", result, 2);
    check("tie_low_votes", votes, 8);

    for (int i = 0; i < N_TREES; i++) leaves[i] = (i % 2 == 0) ? 32'd100 : -32'sd30;
    run_job(1'b1, 0, 1'b1);
    check("sum_result", result, 560);
    check("sum_votes", votes, 0);

    fill(32'h7FFF_FFFF, N_TREES, 32'd0, 0, 32'd0);
    run_job(1'b1, 0, 1'b0);
    check("sat_pos", result, 32'h7FFF_FFFF);

    fill(32'h8000_0000, N_TREES, 32'd0, 0, 32'd0);
    run_job(1'b1, 2, 1'b0);
    check("sat_neg", result, 32'h8000_0000);

    // Timeout: one engine never raises done.
    repeat (2) @(negedge clk);
    #1;
    exp_job   = '{32'd0, 0, 0, 1'b1};
    tree_done = ~N_TREES'(1);
    mode      = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (done || k >= 200) break;
    end
    check("timeout_latency", k, TIMEOUT_CYC + 1);
    check("timeout_error", error, 1);
    check("timeout_result", result, 0);
    @(negedge clk);

    fill(32'd9, 4, 32'd1, 3, 32'd33);
    run_job(1'b0, 0, 1'b0);
    check("after_timeout_error", error, 0);

    // Randomised jobs.
    for (int n = 0; n < 30; n++) begin
      bit m;
      int sty;
      m   = 1'($urandom);
      sty = $urandom_range(0, 3);
      foreach (leaves[i]) begin
        if (!m) begin
          case (sty)
            0:       leaves[i] = $urandom_range(0, 3);
            1:       leaves[i] = $urandom_range(0, N_CLASSES + 3);
            2:       leaves[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 6);
            default: leaves[i] = $urandom_range(0, N_CLASSES - 1);
          endcase
        end else begin
          case (sty)
            0:       leaves[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
            1:       leaves[i] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFF0 : 32'h8000_0010;
            2:       leaves[i] = $urandom;
            default: leaves[i] = ($urandom_range(0, 1) == 1) ? 32'h4000_0000 : 32'hC000_0000;
          endcase
        end
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_job(m, $urandom_range(0, 5), 1'($urandom));
    end

    // Reset asserted during ACCUM aborts with no done pulse.
    @(negedge clk);
    #1;
    foreach (leaves[i]) leaves[i] = $urandom_range(0, N_CLASSES - 1);
    pack_leaves();
    exp_job = model(1'b0);
    mode    = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    tree_done = '0;
    @(negedge clk);
    tree_done = '1;
    repeat (5) @(negedge clk);
    dc0   = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_votes", votes, 0);
    check("midrst_invalid", invalid_votes, 0);
    check("midrst_error", error, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_idle", busy, 0);

    fill(32'd31, 9, 32'd0, 7, 32'd0);
    run_job(1'b0, 0, 1'b0);
    check("post_rst_result", result, 31);
    check("post_rst_votes", votes, 9);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
